// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receive and transmit paths.
// Holds the channel encoding, the default word width and the receiver state type.
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 16;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ALIGN,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous serial line.
// Also provides one-clk rise/fall pulses derived from the synchronized level.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S slave receiver, fully oversampled in the clk domain.
// Delivers one left/right pair per frame once aligned to a left-channel start.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk_in,
    input  logic                  lrclk_in,
    input  logic                  sdata_in,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  frame_error,
    output logic                  aligned
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic bclk_rise;
    logic bclk_lvl_unused;
    logic bclk_fall_unused;
    logic lr_s;
    logic lr_rise_unused;
    logic lr_fall_unused;
    logic sd_s;
    logic sd_rise_unused;
    logic sd_fall_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk    (clk),
        .reset  (reset),
        .d_i    (bclk_in),
        .level_o(bclk_lvl_unused),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk    (clk),
        .reset  (reset),
        .d_i    (lrclk_in),
        .level_o(lr_s),
        .rise_o (lr_rise_unused),
        .fall_o (lr_fall_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sdata_in),
        .level_o(sd_s),
        .rise_o (sd_rise_unused),
        .fall_o (sd_fall_unused)
    );

    i2s_rx_state_t state_q, state_d;

    logic                  lr_prev_q, lr_prev_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  short_l_q, short_l_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  aligned_q, aligned_d;

    logic                  ws_chg;
    logic [CW-1:0]         cnt_inc;
    logic                  word_short;
    logic [DATA_WIDTH-1:0] shift_ins;

    assign ws_chg     = bclk_rise && (lr_s != lr_prev_q);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign word_short = (cnt_inc != CNT_MAX);

    // Bits land left-justified into a cleared word, so short words come out zero-padded.
    assign shift_ins = (sd_s && (cnt_q != CNT_MAX)) ? (shift_q | (MSB_ONE >> cnt_q))
                                                    : shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALIGN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ALIGN: if (ws_chg && (lr_s == I2S_LEFT)) state_d = LEFT;
            LEFT:  if (ws_chg) state_d = RIGHT;
            RIGHT: if (ws_chg) state_d = LEFT;
            default: state_d = ALIGN;
        endcase
    end

    always_comb begin
        lr_prev_d   = bclk_rise ? lr_s : lr_prev_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        left_hold_d = left_hold_q;
        short_l_d   = short_l_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        aligned_d   = aligned_q;
        unique case (state_q)
            ALIGN: begin
                if (ws_chg && (lr_s == I2S_LEFT)) begin
                    shift_d   = '0;
                    cnt_d     = '0;
                    short_l_d = 1'b0;
                    aligned_d = 1'b1;
                end
            end
            LEFT: begin
                if (ws_chg) begin
                    left_hold_d = shift_ins;
                    short_l_d   = word_short;
                    shift_d     = '0;
                    cnt_d       = '0;
                end else if (bclk_rise) begin
                    shift_d = shift_ins;
                    cnt_d   = cnt_inc;
                end
            end
            RIGHT: begin
                if (ws_chg) begin
                    left_d    = left_hold_q;
                    right_d   = shift_ins;
                    valid_d   = 1'b1;
                    err_d     = short_l_q | word_short;
                    short_l_d = 1'b0;
                    shift_d   = '0;
                    cnt_d     = '0;
                end else if (bclk_rise) begin
                    shift_d = shift_ins;
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            left_hold_q <= '0;
            short_l_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            aligned_q   <= 1'b0;
        end else begin
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            left_hold_q <= left_hold_d;
            short_l_q   <= short_l_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            aligned_q   <= aligned_d;
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign frame_error  = err_q;
    assign aligned      = aligned_q;

endmodule
